// File: rtl/periph_in_debounce.sv
// Synchronise, debounce and edge-flag raw peripheral input pins.
// Optional: define PERIPH_IN_FALL_EDGE_EN to also flag falling level edges.
module periph_in_debounce #(
  parameter int BW = 1,
  parameter int DB = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BW-1:0] pin_in,
  input  logic          flag_clr,
  output logic [BW-1:0] level,
  output logic [BW-1:0] edge_flag,
  output logic          irq
);

  localparam int CW = $clog2(DB + 1);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t        st      [BW];
  state_t        st_nxt  [BW];
  logic [CW-1:0] cnt     [BW];
  logic [CW-1:0] cnt_nxt [BW];
  logic [CW-1:0] cnt_inc [BW];
  logic [BW-1:0] term;
  logic [BW-1:0] s1, s2;
  logic [BW-1:0] level_nxt;
  logic [BW-1:0] set_vec;
  logic [BW-1:0] flag_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      level     <= '0;
      edge_flag <= '0;
      irq       <= 1'b0;
      for (int i = 0; i < BW; i++) begin
        st[i]  <= IDLE;
        cnt[i] <= '0;
      end
    end else begin
      s1        <= pin_in;
      s2        <= s1;
      level     <= level_nxt;
      edge_flag <= flag_nxt;
      irq       <= |flag_nxt;
      for (int i = 0; i < BW; i++) begin
        st[i]  <= st_nxt[i];
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // An idle bit always starts counting from zero, so a stale count can never leak in.
  always_comb begin
    term = '0;
    for (int i = 0; i < BW; i++) begin
      cnt_inc[i] = ((st[i] == COUNT) ? cnt[i] : '0) + CW'(1);
      term[i]    = (cnt_inc[i] == CW'(DB));
    end
  end

  always_comb begin
    for (int i = 0; i < BW; i++) begin
      st_nxt[i] = IDLE;
      if ((s2[i] != level[i]) && !term[i])
        st_nxt[i] = COUNT;
    end
  end

  always_comb begin
    level_nxt = level;
    for (int i = 0; i < BW; i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != level[i]) begin
        if (term[i])
          level_nxt[i] = s2[i];
        else
          cnt_nxt[i] = cnt_inc[i];
      end
    end
  end

  // A new set is OR-ed in after the clear so that it survives a simultaneous flag_clr.
  always_comb begin
`ifdef PERIPH_IN_FALL_EDGE_EN
    set_vec = level_nxt ^ level;
`else
    set_vec = level_nxt & ~level;
`endif
    flag_nxt = (edge_flag & ~{BW{flag_clr}}) | set_vec;
  end

endmodule

// File: tb/tb_periph_in_debounce.sv
// Bench for periph_in_debounce: a DB=4 and a DB=1 instance checked against a window-based model.
module tb_periph_in_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic       flag_clr;
  logic [3:0] pin_a, pin_b;
  logic [3:0] level_a, flag_a, level_b, flag_b;
  logic       irq_a, irq_b;

  int checks_total  = 0;
  int checks_passed = 0;

  periph_in_debounce #(.BW(4), .DB(4)) dut_a (
    .clk(clk), .rst(rst), .pin_in(pin_a), .flag_clr(flag_clr),
    .level(level_a), .edge_flag(flag_a), .irq(irq_a)
  );

  periph_in_debounce #(.BW(4), .DB(1)) dut_b (
    .clk(clk), .rst(rst), .pin_in(pin_b), .flag_clr(flag_clr),
    .level(level_b), .edge_flag(flag_b), .irq(irq_b)
  );

  always #5 clk = ~clk;

  // Model: a level flips once the last DB pre-edge s2 samples all disagree with it.
  logic [3:0] m_s1[2], m_s2[2], m_level[2], m_flag[2];
  logic       m_irq[2];
  logic [3:0] m_hist[2][4];
  int         m_db[2];

  typedef struct {
    logic       rst;
    logic [3:0] pin;
    logic       clr;
    logic [3:0] exp_level;
    logic [3:0] exp_flag;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[11];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_update();
    logic [3:0] pins, old_s2, set, mask, win, target;
    for (int j = 0; j < 2; j++) begin
      pins = (j == 0) ? pin_a : pin_b;
      if (rst) begin
        m_s1[j] = '0; m_s2[j] = '0; m_level[j] = '0; m_flag[j] = '0; m_irq[j] = 1'b0;
        for (int b = 0; b < 4; b++) m_hist[j][b] = '0;
      end else begin
        old_s2  = m_s2[j];
        m_s2[j] = m_s1[j];
        m_s1[j] = pins;
        set     = '0;
        mask    = 4'((1 << m_db[j]) - 1);
        for (int b = 0; b < 4; b++) begin
          m_hist[j][b] = {m_hist[j][b][2:0], old_s2[b]};
          win    = m_hist[j][b] & mask;
          target = m_level[j][b] ? 4'h0 : mask;
          if (win == target) begin
`ifdef PERIPH_IN_FALL_EDGE_EN
            set[b] = 1'b1;
`else
            set[b] = ~m_level[j][b];
`endif
            m_level[j][b] = ~m_level[j][b];
          end
        end
        m_flag[j] = (m_flag[j] & ~{4{flag_clr}}) | set;
        m_irq[j]  = |m_flag[j];
      end
    end
  endtask

  // One clock: update the model on the edge, compare on the following falling edge.
  task automatic apply_stimulus();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_output("model_level_a", level_a, m_level[0]);
    check_output("model_flag_a",  flag_a,  m_flag[0]);
    check_output("model_irq_a",   irq_a,   m_irq[0]);
    check_output("model_level_b", level_b, m_level[1]);
    check_output("model_flag_b",  flag_b,  m_flag[1]);
    check_output("model_irq_b",   irq_b,   m_irq[1]);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) apply_stimulus();
  endtask

  task automatic clear_pulse();
    flag_clr = 1'b1;
    apply_stimulus();
    flag_clr = 1'b0;
  endtask

  initial begin
    int hi_cnt;
    logic seen;

    m_db[0] = 4;
    m_db[1] = 1;
    for (int j = 0; j < 2; j++) begin
      m_s1[j] = '0; m_s2[j] = '0; m_level[j] = '0; m_flag[j] = '0; m_irq[j] = 1'b0;
      for (int b = 0; b < 4; b++) m_hist[j][b] = '0;
    end

    vecs[0]  = '{1'b1, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[1]  = '{1'b1, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[2]  = '{1'b1, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[3]  = '{1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[4]  = '{1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[5]  = '{1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[6]  = '{1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[7]  = '{1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[8]  = '{1'b0, 4'hF, 1'b0, 4'hF, 4'hF, 1'b1};
    vecs[9]  = '{1'b0, 4'hF, 1'b1, 4'hF, 4'h0, 1'b0};
    vecs[10] = '{1'b0, 4'hF, 1'b0, 4'hF, 4'h0, 1'b0};

    flag_clr = 1'b0;
    pin_b    = 4'h0;

    for (int i = 0; i < 11; i++) begin
      rst      = vecs[i].rst;
      pin_a    = vecs[i].pin;
      flag_clr = vecs[i].clr;
      apply_stimulus();
      check_output($sformatf("vec%0d_level", i), level_a, vecs[i].exp_level);
      check_output($sformatf("vec%0d_flag", i),  flag_a,  vecs[i].exp_flag);
      check_output($sformatf("vec%0d_irq", i),   irq_a,   vecs[i].exp_irq);
    end
    flag_clr = 1'b0;

    // Glitch reject: 3-cycle pulse vanishes, 4-cycle pulse yields a 4-cycle level.
    pin_a = 4'hE;
    ticks(8);
    check_output("glitch_setup_level", level_a, 4'hE);
    clear_pulse();
    check_output("glitch_setup_flag", flag_a, 4'h0);
    pin_a[0] = 1'b1;
    ticks(3);
    pin_a[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      apply_stimulus();
      seen = seen | level_a[0];
    end
    check_output("glitch3_level", seen, 1'b0);
    check_output("glitch3_flag", flag_a[0], 1'b0);
    check_output("glitch3_irq", irq_a, 1'b0);
    pin_a[0] = 1'b1;
    ticks(4);
    pin_a[0] = 1'b0;
    hi_cnt = 0;
    for (int k = 0; k < 14; k++) begin
      apply_stimulus();
      if (level_a[0]) hi_cnt++;
    end
    check_output("glitch4_high_cycles", hi_cnt, 4);
    check_output("glitch4_flag", flag_a[0], 1'b1);
    check_output("glitch4_irq", irq_a, 1'b1);

    // Clear collision: flag[1] pending, clr lands on the edge level[2] rises.
    pin_a = 4'b1000;
    ticks(8);
    clear_pulse();
    pin_a = 4'b1010;
    ticks(8);
    check_output("collide_pre_flag", flag_a, 4'b0010);
    pin_a = 4'b1110;
    ticks(5);
    check_output("collide_pre_level2", level_a[2], 1'b0);
    clear_pulse();
    check_output("collide_flag", flag_a, 4'b0100);
    check_output("collide_irq", irq_a, 1'b1);
    check_output("collide_level", level_a, 4'b1110);
    apply_stimulus();
    check_output("collide_flag_hold", flag_a, 4'b0100);

    // Falling edge on bit 3 with DB+2 latency.
    clear_pulse();
    pin_a[3] = 1'b0;
    ticks(5);
    check_output("fall_level3_early", level_a[3], 1'b1);
    apply_stimulus();
    check_output("fall_level3", level_a[3], 1'b0);
`ifdef PERIPH_IN_FALL_EDGE_EN
    check_output("fall_flag3", flag_a[3], 1'b1);
    check_output("fall_irq", irq_a, 1'b1);
`else
    check_output("fall_flag3", flag_a[3], 1'b0);
    check_output("fall_irq", irq_a, 1'b0);
`endif

    // Reset three cycles into a debounce restarts the count from the first post-reset sample.
    pin_a = 4'h0;
    ticks(8);
    clear_pulse();
    pin_a = 4'b0010;
    ticks(3);
    rst = 1'b1;
    apply_stimulus();
    check_output("midrst_level", level_a, 4'h0);
    check_output("midrst_flag", flag_a, 4'h0);
    check_output("midrst_irq", irq_a, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      apply_stimulus();
      check_output($sformatf("midrst_early%0d", k), level_a[1], 1'b0);
    end
    apply_stimulus();
    check_output("midrst_level1", level_a[1], 1'b1);
    check_output("midrst_flag1", flag_a[1], 1'b1);

    // DB=1: three-edge latency and a single-cycle pulse passes through.
    clear_pulse();
    pin_b[0] = 1'b1;
    ticks(2);
    check_output("db1_early", level_b[0], 1'b0);
    apply_stimulus();
    check_output("db1_level", level_b[0], 1'b1);
    check_output("db1_flag", flag_b[0], 1'b1);
    clear_pulse();
    pin_b[0] = 1'b0;
    ticks(4);
    clear_pulse();
    pin_b[0] = 1'b1;
    apply_stimulus();
    pin_b[0] = 1'b0;
    hi_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      apply_stimulus();
      if (level_b[0]) hi_cnt++;
    end
    check_output("db1_pulse_cycles", hi_cnt, 1);
    check_output("db1_pulse_flag", flag_b[0], 1'b1);

    // Random pins, clears and occasional resets against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 3) == 0) pin_a[b] = ~pin_a[b];
        if ($urandom_range(0, 2) == 0) pin_b[b] = ~pin_b[b];
      end
      flag_clr = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 199) == 0);
      apply_stimulus();
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
